// File: rtl/pattern_game_ctrl.sv
// pattern_game_ctrl: memory-game round controller.
// It generates a pseudo-random pattern, shows it on the one-hot LEDs, collects
// the player's key presses, then reports pass/fail and a saturating win count.
// Optional feature: define INPUT_TIMEOUT_EN to give up on an idle player after
// INPUT_TIMEOUT cycles without a key press.
module pattern_game_ctrl #(
    parameter int PAT_LEN       = 4,
    parameter int SHOW_TIME     = 500000,
    parameter int GAP_TIME      = 100000,
    parameter int INPUT_TIMEOUT = 5000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [3:0] KEY,
    output logic [3:0] LED,
    output logic       ENABLE,
    output logic       IS_EQUAL,
    output logic [3:0] ROUND,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW_ON,
        SHOW_GAP,
        INPUT,
        RESULT
    } state_t;

    // The timer only needs to cover the longest interval actually timed.
    localparam int SHOW_GAP_MAX = (SHOW_TIME > GAP_TIME) ? SHOW_TIME : GAP_TIME;
`ifdef INPUT_TIMEOUT_EN
    localparam int TMR_MAX = (INPUT_TIMEOUT > SHOW_GAP_MAX) ? INPUT_TIMEOUT : SHOW_GAP_MAX;
`else
    localparam int TMR_MAX = SHOW_GAP_MAX;
`endif
    localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_TIME - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_TIME - 1);
`ifdef INPUT_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(INPUT_TIMEOUT - 1);
`endif
    localparam logic [3:0] IDX_LAST = 4'(PAT_LEN - 1);
    localparam logic [3:0] IDX_END  = 4'(PAT_LEN);

    // Reject parameter values the step index and timer were not sized for.
    if (PAT_LEN < 1 || PAT_LEN > 8 || SHOW_TIME < 1 || GAP_TIME < 1 || INPUT_TIMEOUT < 1) begin : g_param_check
        $error("pattern_game_ctrl: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             start_prev_q, start_prev_d;
    logic [3:0]       key_prev_q, key_prev_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       idx_q, idx_d;
    logic             mismatch_q, mismatch_d;
    logic             enable_q, enable_d;
    logic             is_equal_q, is_equal_d;
    logic [3:0]       round_q, round_d;
    logic [1:0]       pattern_q [8];
    logic [1:0]       pattern_d [8];

    logic       lfsr_fb;
    logic       start_edge;
    logic       key_press;
    logic       key_onehot;
    logic [1:0] key_code;
    logic [2:0] pat_sel;
    logic [1:0] cur_step;

    assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign start_edge = START & ~start_prev_q;
    assign key_press  = (key_prev_q == 4'b0000) && (KEY != 4'b0000);
    assign key_onehot = (KEY != 4'b0000) && ((KEY & (KEY - 4'd1)) == 4'b0000);
    assign pat_sel    = idx_q[2:0];
    assign cur_step   = pattern_q[pat_sel];

    assign ENABLE   = enable_q;
    assign IS_EQUAL = is_equal_q;
    assign ROUND    = round_q;
    assign BUSY     = (state_q != IDLE) && (state_q != RESULT);

    // Encode a single-bit key press into the 2-bit step value it represents.
    always_comb begin
        key_code = 2'd0;
        case (KEY)
            4'b0010: key_code = 2'd1;
            4'b0100: key_code = 2'd2;
            4'b1000: key_code = 2'd3;
            default: key_code = 2'd0;
        endcase
    end

    // Next-state, datapath updates and LED drive for the round sequence.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[6:0], lfsr_fb};
        start_prev_d = START;
        key_prev_d   = KEY;
        timer_d      = '0;
        idx_d        = idx_q;
        mismatch_d   = mismatch_q;
        enable_d     = enable_q;
        is_equal_d   = is_equal_q;
        round_d      = round_q;
        pattern_d    = pattern_q;
        LED          = 4'b0000;

        // The polynomial is maximal-length so zero is unreachable from 8'hA5;
        // this guard keeps the LFSR out of its lock-up state regardless.
        if (lfsr_d == 8'h00) begin
            lfsr_d = 8'h01;
        end

        case (state_q)
            IDLE, RESULT: begin
                if (start_edge) begin
                    state_d    = GEN;
                    enable_d   = 1'b0;
                    is_equal_d = 1'b0;
                    idx_d      = 4'd0;
                end
            end

            GEN: begin
                pattern_d[pat_sel] = lfsr_q[1:0];
                if (idx_q == IDX_LAST) begin
                    idx_d   = 4'd0;
                    state_d = SHOW_ON;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            SHOW_ON: begin
                LED = 4'b0001 << cur_step;
                if (timer_q == SHOW_LAST) begin
                    state_d = SHOW_GAP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            SHOW_GAP: begin
                if (timer_q == GAP_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        state_d    = INPUT;
                        idx_d      = 4'd0;
                        mismatch_d = 1'b0;
                    end else begin
                        state_d = SHOW_ON;
                        idx_d   = idx_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            INPUT: begin
                LED = KEY;
                if (idx_q == IDX_END) begin
                    state_d    = RESULT;
                    enable_d   = 1'b1;
                    is_equal_d = !mismatch_q;
                    if (!mismatch_q && (round_q != 4'd15)) begin
                        round_d = round_q + 4'd1;
                    end
                end else if (key_press) begin
                    idx_d = idx_q + 4'd1;
                    if (!key_onehot || (key_code != cur_step)) begin
                        mismatch_d = 1'b1;
                    end
                end
`ifdef INPUT_TIMEOUT_EN
                else if (timer_q == TIMEOUT_LAST) begin
                    mismatch_d = 1'b1;
                    state_d    = RESULT;
                    enable_d   = 1'b1;
                    is_equal_d = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any round in progress.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            lfsr_q       <= 8'hA5;
            start_prev_q <= 1'b0;
            key_prev_q   <= 4'b0000;
            timer_q      <= '0;
            idx_q        <= 4'd0;
            mismatch_q   <= 1'b0;
            enable_q     <= 1'b0;
            is_equal_q   <= 1'b0;
            round_q      <= 4'd0;
            pattern_q    <= '{default: 2'b00};
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            start_prev_q <= start_prev_d;
            key_prev_q   <= key_prev_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            mismatch_q   <= mismatch_d;
            enable_q     <= enable_d;
            is_equal_q   <= is_equal_d;
            round_q      <= round_d;
            pattern_q    <= pattern_d;
        end
    end

endmodule
